axis_upsize_pkt: RTL
====================

# axis_upsize_pkt

Packet-aware AXI-Stream width upsizer. Packs RATIO consecutive WIDTH-bit input beats into one WIDTH*RATIO-bit output beat, little-endian: the first beat goes in the low slot. A short final word is flushed when s_axis_tlast arrives. Sustains one input beat per cycle with a registered output stage. It sits between narrow producers (DMA read ports, packet parsers) and wide datapath or memory-write stages.

## Interface
Parameters:
- WIDTH, 32, input data width in bits; multiple of 8, ≥8
- RATIO, 2, output/input width ratio; integer ≥2

Ports:
- aclk  in  1  clock; all logic is on the rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when high with tvalid
- s_axis_tdata  in  WIDTH  input data
- s_axis_tlast  in  1  last beat of packet
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  WIDTH*RATIO  packed output word
- m_axis_tlast  out  1  output word holds the packet's last beat
- m_axis_tkeep  out  WIDTH*RATIO/8  byte-valid mask; exists only with AXIS_UPSIZE_TKEEP_EN
- slot_cnt  out  $clog2(RATIO)  number of slots currently filled in the accumulator (status)

## Operation
- Storage:
  - Accumulator of RATIO-1 slots.
  - Slot counter cnt, range 0..RATIO-1.
  - Output register holding tdata, tlast, tkeep and m_axis_tvalid.
- Accept condition: s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - This is combinational from m_axis_tready and is independent of s_axis_tvalid and s_axis_tlast.
- On an accepted beat, the beat is final when cnt == RATIO-1 or s_axis_tlast == 1.
- Non-final beat:
  - Store the beat in slot cnt (bits [cnt*WIDTH +: WIDTH]).
  - Increment cnt.
- Final beat:
  - Load the output register with the accumulator slots 0..cnt-1 plus the new beat in slot cnt.
  - Zero-fill slots cnt+1..RATIO-1.
  - m_axis_tlast = s_axis_tlast.
  - Set m_axis_tvalid = 1 and clear cnt to 0.
- Output handshake:
  - When m_axis_tvalid && m_axis_tready and no new final beat arrives in the same cycle, clear m_axis_tvalid.
  - If a final beat is accepted in the same cycle, reload the output register and keep m_axis_tvalid = 1 (back-to-back words, no bubble).
- While m_axis_tvalid && !m_axis_tready:
  - m_axis_tdata, m_axis_tlast and m_axis_tkeep hold stable.
  - s_axis_tready = 0, so cnt and the accumulator freeze.
- A tlast beat with cnt == 0 produces a one-slot word (slot 0 valid, rest zero).
- A packet whose length is an exact multiple of RATIO produces no extra word. tlast is carried on the last full word.
- Accumulator contents above cnt are don't-care internally. They never appear on m_axis_tdata; zero-fill applies there.
- slot_cnt = cnt.

## Timing
- Reset (aresetn low, asynchronous; effective immediately, no clock needed):
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, m_axis_tkeep = 0, cnt = 0, slot_cnt = 0.
  - A partially filled word is discarded.
  - s_axis_tready = 1 during reset, as a combinational consequence of m_axis_tvalid = 0.
  - Reset deassertion is assumed synchronised externally.
- Latency: m_axis_tvalid rises on the clock edge that accepts the final beat, so the word is visible 1 cycle after the final beat handshake.
- Throughput:
  - 1 input beat per cycle when m_axis_tready is held at 1.
  - 1 output word every RATIO cycles for full words, or every cycle for back-to-back single-beat packets.
- No combinational path from s_axis_* to m_axis_*.

## Configuration
- Macro: AXIS_UPSIZE_TKEEP_EN.
- Defined:
  - m_axis_tkeep port is present.
  - Byte lanes of filled slots 0..cnt are 1; zero-filled slots are 0.
  - tkeep is registered with m_axis_tdata and held under backpressure.
- Undefined:
  - m_axis_tkeep port and its logic are absent.
  - Downstream must infer partial words from packet length.
  - All other behaviour is identical.

## Test plan
- WIDTH=32, RATIO=4, continuous input 0x1,0x2,…,0x8 with tlast on 0x8, m_axis_tready=1:
  - Required: words 0x00000004_00000003_00000002_00000001 then 0x8_7_6_5.
  - Required: m_axis_tlast only on the second word.
  - Required: s_axis_tready stays 1 throughout.
- RATIO=4, 6-beat packet 0xA1..0xA6, tlast on 0xA6:
  - Required: second word = 0x0_0_A6_A5 with tlast = 1.
  - Required, with macro: tkeep = 0x00FF.
  - Required: slot_cnt returns to 0 after that word.
- Single-beat packets every cycle (tlast=1 on every beat), m_axis_tready=1:
  - Required: one output word per cycle, no bubbles, each with tlast = 1 and the data in slot 0.
- Hold m_axis_tready=0 for 5 cycles while a word is valid:
  - Required: s_axis_tready=0 and m_axis_tdata/tlast/tkeep unchanged for those 5 cycles.
  - Required: on releasing m_axis_tready, the next full word follows with no data loss.
- Assert aresetn=0 between edges with slot_cnt=2:
  - Required: m_axis_tvalid and slot_cnt go to 0 immediately.
  - Required: the next packet after release packs from slot 0 with no stale data.
- RATIO=2, WIDTH=8, random valid/ready toggling over 1000 beats:
  - Required: the scoreboard matches the reference packing, with tlast placement preserved per packet.

Source files
------------

// File: rtl/axis_upsize_pkt.sv
// axis_upsize_pkt
//   Packet-aware AXI-Stream width upsizer. It packs RATIO consecutive WIDTH-bit
//   input beats into one WIDTH*RATIO-bit output word, little-endian: the first
//   beat lands in the low slot. When s_axis_tlast arrives, a short final word is
//   flushed with its unused upper slots zero-filled. The output stage is
//   registered and accepts one input beat per cycle.
//
//   Optional feature: define AXIS_UPSIZE_TKEEP_EN to add the m_axis_tkeep port.
//
//   Ports
//     aclk, aresetn         clock (rising edge), asynchronous active-low reset
//     s_axis_tvalid/tready  input beat handshake
//     s_axis_tdata/tlast    input beat data, end-of-packet marker
//     m_axis_tvalid/tready  output word handshake
//     m_axis_tdata/tlast    packed output word, end-of-packet marker
//     m_axis_tkeep          byte-valid mask (only with AXIS_UPSIZE_TKEEP_EN)
//     slot_cnt              number of accumulator slots currently filled
module axis_upsize_pkt #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned RATIO = 2,
  localparam int unsigned CW    = $clog2(RATIO),
  localparam int unsigned OW    = WIDTH * RATIO
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OW-1:0]        m_axis_tdata,
  output logic                 m_axis_tlast,
`ifdef AXIS_UPSIZE_TKEEP_EN
  output logic [OW/8-1:0]      m_axis_tkeep,
`endif
  output logic [CW-1:0]        slot_cnt
);

  logic [(RATIO-1)*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       tvalid_q, tvalid_d;
  logic [OW-1:0]              tdata_q, tdata_d;
  logic                       tlast_q, tlast_d;
`ifdef AXIS_UPSIZE_TKEEP_EN
  logic [OW/8-1:0]            tkeep_q, tkeep_d;
`endif

  // Accumulator padded by one zero slot, so the output loop can index every slot uniformly.
  logic [OW-1:0] acc_ext;
  logic          s_hs;
  logic          fin;

  assign acc_ext       = {{WIDTH{1'b0}}, acc_q};
  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign fin           = (cnt_q == CW'(RATIO - 1)) || s_axis_tlast;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
`ifdef AXIS_UPSIZE_TKEEP_EN
    tkeep_d  = tkeep_q;
`endif

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    if (s_hs) begin
      if (fin) begin
        // A final beat accepted while the current word drains reloads the
        // register directly, so back-to-back words have no bubble.
        for (int unsigned i = 0; i < RATIO; i++) begin
          if (CW'(i) < cnt_q) begin
            tdata_d[i*WIDTH +: WIDTH] = acc_ext[i*WIDTH +: WIDTH];
          end else if (CW'(i) == cnt_q) begin
            tdata_d[i*WIDTH +: WIDTH] = s_axis_tdata;
          end else begin
            tdata_d[i*WIDTH +: WIDTH] = '0;
          end
`ifdef AXIS_UPSIZE_TKEEP_EN
          if (CW'(i) <= cnt_q) begin
            tkeep_d[i*(WIDTH/8) +: WIDTH/8] = '1;
          end else begin
            tkeep_d[i*(WIDTH/8) +: WIDTH/8] = '0;
          end
`endif
        end
        tlast_d  = s_axis_tlast;
        tvalid_d = 1'b1;
        cnt_d    = '0;
      end else begin
        for (int unsigned i = 0; i < RATIO - 1; i++) begin
          if (CW'(i) == cnt_q) begin
            acc_d[i*WIDTH +: WIDTH] = s_axis_tdata;
          end
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
`ifdef AXIS_UPSIZE_TKEEP_EN
      tkeep_q  <= '0;
`endif
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
`ifdef AXIS_UPSIZE_TKEEP_EN
      tkeep_q  <= tkeep_d;
`endif
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
`ifdef AXIS_UPSIZE_TKEEP_EN
  assign m_axis_tkeep  = tkeep_q;
`endif
  assign slot_cnt      = cnt_q;

endmodule
